// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx
//   Read-side consumer for a show-ahead FIFO. It pops one word whenever the
//   FIFO is non-empty and en=1, then sends that word on a single line as an
//   asynchronous-serial frame:
//     start(0), DATA_WIDTH data bits LSB first, optional even parity, stop(1)
//   Each bit is held for CLKS_PER_BIT clocks (CLKS_PER_BIT >= 2).
//
// Ports
//   clk        : single clock (FIFO read-side clock)
//   rst_n      : asynchronous active-low reset
//   en         : allows a new frame to start; only looked at while idle
//   empty      : FIFO empty flag
//   rdata      : FIFO head word, valid whenever empty=0
//   rinc       : FIFO pop strobe (combinational, one cycle per frame)
//   tx         : serial line, idles high (registered)
//   busy       : frame in progress (registered)
//   frame_done : one-cycle pulse in the first idle cycle after a frame
module fifo_serial_tx #(
    parameter int DATA_WIDTH   = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]            state;
    logic [BAUD_W-1:0]     baud;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_next;
    logic                  parity;
    logic                  start;
    logic                  bit_end;

    assign start      = (state == S_IDLE) && en && !empty;
    // Gated by rst_n so the FIFO is never popped while the block is held in reset.
    assign rinc       = start && rst_n;
    assign bit_end    = (baud == LAST_BAUD);
    assign shreg_next = shreg >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            baud       <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity     <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shreg   <= rdata;
                        // Parity is taken from the captured word, not recomputed
                        // from the shifting register.
                        parity  <= ^rdata;
                        bit_cnt <= '0;
                        baud    <= '0;
                        state   <= S_START;
                        tx      <= 1'b0;   // start bit begins on the capture edge
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    if (!bit_end) begin
                        baud <= baud + BAUD_W'(1);
                    end else begin
                        // Bit boundary: tx is loaded with the next bit's value so
                        // the line changes exactly on the boundary edge.
                        baud <= '0;
                        case (state)
                            S_START: begin
                                state <= S_DATA;
                                tx    <= shreg[0];
                            end
                            S_DATA: begin
                                shreg   <= shreg_next;
                                bit_cnt <= bit_cnt + BIT_W'(1);
                                if (bit_cnt == LAST_BIT) begin
                                    if (PARITY_EN != 0) begin
                                        state <= S_PARITY;
                                        tx    <= parity;
                                    end else begin
                                        state <= S_STOP;
                                        tx    <= 1'b1;
                                    end
                                end else begin
                                    tx <= shreg_next[0];
                                end
                            end
                            S_PARITY: begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                            S_STOP: begin
                                state      <= S_IDLE;
                                tx         <= 1'b1;
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                            end
                            default: begin
                                // Unreachable encodings fall back to idle.
                                state <= S_IDLE;
                                tx    <= 1'b1;
                                busy  <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx. The main instance (parity on) is checked every
// cycle against a frame-level model; a second instance with parity off is
// checked with directed literal expectations. Both run at 4 clocks per bit.
module tb_fifo_serial_tx;

    localparam int CPB  = 4;
    localparam int DW   = 4;
    localparam int FLEN = (2 + DW + 1) * CPB;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b1;
    logic       empty;
    logic [3:0] rdata;
    logic       rinc, tx, busy, frame_done;

    logic       en0    = 1'b0;
    logic       empty0 = 1'b1;
    logic [3:0] rdata0 = 4'h0;
    logic       rinc0, tx0, busy0, fd0;

    int vectors     = 0;
    int miscompares = 0;

    // Simple show-ahead FIFO feeding the main instance.
    logic [3:0] mem [64];
    int         wr_ptr    = 0;
    int         rd_ptr    = 0;
    int         rinc_cnt  = 0;
    int         rinc0_cnt = 0;

    assign empty = (rd_ptr == wr_ptr);
    assign rdata = mem[rd_ptr];

    fifo_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .empty(empty), .rdata(rdata),
        .rinc(rinc), .tx(tx), .busy(busy), .frame_done(frame_done)
    );

    fifo_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en0), .empty(empty0), .rdata(rdata0),
        .rinc(rinc0), .tx(tx0), .busy(busy0), .frame_done(fd0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rinc) begin
            rd_ptr   <= rd_ptr + 1;
            rinc_cnt <= rinc_cnt + 1;
        end
        if (rinc0) rinc0_cnt <= rinc0_cnt + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model of the main instance ----------------
    // A frame is a list of line levels, one per bit; the line shows bit
    // (pos / CPB) while a frame is active, and 1 otherwise.
    function automatic logic [6:0] frame_bits(input logic [3:0] d);
        return {1'b1, ^d, d, 1'b0};
    endfunction

    logic       m_active = 1'b0;
    logic       m_done   = 1'b0;
    int         m_pos    = 0;
    logic [6:0] m_bits   = 7'h7f;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_pos    <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_active) begin
                if (m_pos == FLEN - 1) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end else begin
                    m_pos <= m_pos + 1;
                end
            end else if (en && !empty) begin
                m_active <= 1'b1;
                m_pos    <= 0;
                m_bits   <= frame_bits(rdata);
            end
        end
    end

    always @(negedge clk) begin
        chk("tx", tx, m_active ? int'(m_bits[m_pos / CPB]) : 1);
        chk("busy", busy, m_active);
        chk("frame_done", frame_done, m_done);
        chk("rinc", rinc, rst_n && !m_active && en && !empty);
    end

    // ---------------- directed helpers ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [3:0] d);
        mem[wr_ptr] = d;
        wr_ptr++;
    endtask

    // Follows one frame on the selected instance: line level in cycle 1 of
    // each bit against seq[bit], busy length, and frame_done after it.
    // Returns the number of cycles spent waiting for busy.
    task automatic watch(input string name, input bit sel, input logic [6:0] seq,
                         input int nb, output int gap);
        int w;
        int c;
        w = 0;
        @(negedge clk);
        while (!(sel ? busy0 : busy) && w < 200) begin
            @(negedge clk);
            w++;
        end
        gap = w;
        chk({name, "_start"}, int'(w < 200), 1);
        c = 0;
        while ((sel ? busy0 : busy) && c < 200) begin
            if (c % CPB == 1 && c / CPB < 7)
                chk({name, "_bit"}, sel ? tx0 : tx, seq[c / CPB]);
            c++;
            @(negedge clk);
        end
        chk({name, "_len"}, c, nb * CPB);
        chk({name, "_done"}, sel ? fd0 : frame_done, 1);
    endtask

    initial begin
        int gap;
        int base;
        int k;

        // Reset held with a non-empty FIFO and en=1.
        push(4'hA);
        tick(3);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rinc", rinc, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_rinc", rinc, 1);

        // Single frame 4'hA: 0,0,1,0,1,0,1 over 28 cycles, one pop.
        watch("frameA", 1'b0, 7'b1010100, 7, gap);
        tick(3);
        chk("frameA_pops", rinc_cnt, 1);

        // Back-to-back 4'h7 then 4'h1, both with parity 1, one idle cycle between.
        push(4'h7);
        push(4'h1);
        watch("frame7", 1'b0, 7'b1101110, 7, gap);
        chk("b2b_idle_tx", tx, 1);
        chk("b2b_idle_busy", busy, 0);
        watch("frame1", 1'b0, 7'b1100010, 7, gap);
        chk("b2b_gap", gap, 0);
        tick(6);
        chk("b2b_pops", rinc_cnt, 3);
        chk("b2b_empty", empty, 1);

        // Parity disabled, 4'h3: 0,1,1,0,0,1 over 24 cycles.
        rdata0 = 4'h3;
        empty0 = 1'b0;
        en0    = 1'b1;
        tick(1);
        empty0 = 1'b1;
        watch("nopar3", 1'b1, 7'b0100110, 6, gap);
        tick(2);
        chk("nopar_pops", rinc0_cnt, 1);
        chk("nopar_idle_tx", tx0, 1);

        // Gating: en=0 with data waiting.
        en = 1'b0;
        push(4'h9);
        base = rinc_cnt;
        tick(10);
        chk("gate_pops", rinc_cnt, base);
        chk("gate_tx", tx, 1);
        chk("gate_busy", busy, 0);
        // en drops mid-frame: frame finishes, next word stays in the FIFO.
        en = 1'b1;
        tick(7);
        en = 1'b0;
        push(4'hB);
        k = 0;
        while (busy && k < 100) begin
            tick(1);
            k++;
        end
        chk("gate_finish", int'(k < 100), 1);
        tick(10);
        chk("gate_mid_pops", rinc_cnt, base + 1);
        chk("gate_mid_busy", busy, 0);

        // Reset during data bit 2 of 4'hB; 4'hC must be the next word sent.
        en = 1'b1;
        push(4'hC);
        tick(1);
        tick(13);
        chk("mid_tx_before", tx, 0);
        chk("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rinc", rinc, 0);
        tick(2);
        rst_n = 1'b1;
        watch("frameC", 1'b0, 7'b1011000, 7, gap);
        tick(4);
        chk("rst_pops", rinc_cnt, base + 3);
        chk("rst_empty", empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_serial_tx.md
# fifo_serial_tx

Read-side consumer for the 4-bit asynchronous-clock-domain FIFO in the TT16 tile. The block pops one word at a time whenever the FIFO is non-empty. It then serializes each word onto a single output pin as an asynchronous-serial frame: start bit, data bits LSB first, optional even parity, stop bit. It sits on the FIFO read port in place of the manual read-request pin and drives one dedicated output as the serial line.

## Interface
- DATA_WIDTH, 4, width of FIFO word and of the frame data field.
- CLKS_PER_BIT, 16, clk cycles per serial bit. Legal values are ≥2; values below 2 are unsupported.
- PARITY_EN, 1, 1 = insert even-parity bit after data; 0 = no parity bit.
- clk  input  1  single clock for all logic. This is the same clock as the FIFO read side.
- rst_n  input  1  reset, asynchronous and active-low.
- en  input  1  permits starting a new frame. It is sampled only in IDLE.
- empty  input  1  FIFO empty flag.
- rdata  input  DATA_WIDTH  FIFO head word. It is valid whenever empty=0 (show-ahead read).
- rinc  output  1  FIFO pop strobe, one cycle wide.
- tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is in progress (state ≠ IDLE).
- frame_done  output  1  one-cycle pulse after each completed frame.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If en=1 and empty=0, rinc=1 combinationally in that cycle.
  - At that clock edge: shift register ← rdata, bit counter ← 0, baud counter ← 0, state → START.
  - Otherwise remain in IDLE with rinc=0.
- rinc is asserted only in IDLE, and exactly once per frame.
- START: tx=0 for CLKS_PER_BIT cycles, then → DATA.
- DATA:
  - tx = shift register bit 0. Each bit lasts CLKS_PER_BIT cycles.
  - Shift right at the end of each bit.
  - After DATA_WIDTH bits, go to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY:
  - tx = XOR of the captured word (even parity). The parity value is latched at capture.
  - Duration is CLKS_PER_BIT cycles, then → STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then → IDLE.
- frame_done=1 in the first IDLE cycle after STOP completes.
- Baud counter width is clog2(CLKS_PER_BIT). It resets to 0 at every bit boundary; no free-running wrap.
- Bit counter width is clog2(DATA_WIDTH+1).
- en=0 mid-frame: the current frame completes normally; no new frame starts.
- empty toggling mid-frame: ignored.
- rst_n low at any time:
  - Immediate async clear: state IDLE, tx=1, busy=0, frame_done=0, counters 0, shift register 0.
  - rinc=0 while in reset.
  - A word already popped but not fully sent is discarded; it is not re-read.

## Timing
- Reset values: tx=1, busy=0, rinc=0, frame_done=0.
- Pop-to-line latency: tx falls on the clk edge that captures the word (the cycle after rinc=1 is seen at the edge).
- Frame length: (2 + DATA_WIDTH + PARITY_EN) × CLKS_PER_BIT cycles of busy=1.
- Back-to-back frames are separated by exactly one IDLE cycle (tx=1, frame_done=1, rinc=1 if en && !empty).
- Maximum throughput: one word per frame length + 1 cycles.
- tx, busy and frame_done are registered outputs. rinc is combinational from state, en and empty.

## Test plan
- Reset: hold rst_n=0 with empty=0, en=1 → tx=1, busy=0, rinc=0. Deassert rst_n → rinc=1 in the first cycle after release.
- Single frame, default params (CLKS_PER_BIT set to 4 in bench), rdata=4'hA, one word in FIFO:
  - Exactly one rinc pulse.
  - tx sequence per 4-cycle bit: 0,0,1,0,1,0,1 (start, data 0,1,0,1, parity 0, stop).
  - busy high for 28 cycles, then frame_done pulses once.
- Back-to-back: FIFO holds 4'h7 then 4'h1, PARITY_EN=1:
  - Frames carry parity 1 then 1.
  - Exactly one idle tx=1 cycle between stop of frame 1 and start of frame 2.
  - Two rinc pulses; empty seen high afterward, then no further rinc.
- PARITY_EN=0, rdata=4'h3 → tx 0,1,1,0,0,1, busy for 24 cycles.
- Gating: en=0 with non-empty FIFO → no rinc, tx stays 1. Drop en mid-frame → frame finishes, no next pop.
- Reset mid-frame (during DATA bit 2):
  - tx=1 and busy=0 asynchronously.
  - After release with the FIFO still non-empty, the next word is popped. The interrupted word is not resent.
